// File: rtl/trdb_d5m_pkg.sv
// rtl/trdb_d5m_pkg.sv - shared types and constants for the D5M capture block.
package trdb_d5m_pkg;

    localparam int FRAME_CNT_W = 16;
    // Widest stream pixel a beat can carry; the top uses the low OUT_W bits.
    localparam int BEAT_DATA_W = 16;

    typedef enum logic [1:0] {
        SYNC,
        WAIT_FRAME,
        IN_FRAME,
        DROP
    } tECaptureState;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   sof;
        logic                   eol;
    } tSPixelBeat;

endpackage

// File: rtl/trdb_d5m_pixel_fifo.sv
// rtl/trdb_d5m_pixel_fifo.sv - first-word-fall-through pixel beat FIFO.
module trdb_d5m_pixel_fifo
    import trdb_d5m_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  tSPixelBeat push_beat,
    input  logic       pop,
    output tSPixelBeat head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    tSPixelBeat      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_beat;
    end

endmodule

// File: rtl/trdb_d5m_capture.sv
// rtl/trdb_d5m_capture.sv - D5M pixel bus capture with crop window; TRDB_D5M_TEST_PATTERN_EN selects a row/col pattern.
module trdb_d5m_capture
    import trdb_d5m_pkg::*;
#(
    parameter  int PIX_W      = 12,
    parameter  int OUT_W      = 12,
    parameter  int FIFO_DEPTH = 16,
    parameter  int MAX_COLS   = 2592,
    parameter  int MAX_ROWS   = 1944,
    localparam int CW         = $clog2(MAX_COLS + 1),
    localparam int RW         = $clog2(MAX_ROWS + 1)
) (
    input  logic                   ul1Clock,
    input  logic                   ul1Reset,
    input  logic                   ul1Fval,
    input  logic                   ul1Lval,
    input  logic [PIX_W-1:0]       ulData,
    input  logic [CW-1:0]          ulColStart,
    input  logic [CW-1:0]          ulColCount,
    input  logic [RW-1:0]          ulRowStart,
    input  logic [RW-1:0]          ulRowCount,
    input  logic                   ul1ClearOvf,
    output logic                   ul1Valid,
    input  logic                   ul1Ready,
    output logic [OUT_W-1:0]       ulPixel,
    output logic                   ul1Sof,
    output logic                   ul1Eol,
    output logic                   ul1Overflow,
    output logic [FRAME_CNT_W-1:0] ulFrameCount,
    output logic                   ul1Busy
);

    localparam logic [CW-1:0] COL_MAX = CW'(MAX_COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(MAX_ROWS);

    tECaptureState    state_q, state_d;
    logic             fval_q, lval_q, fval_prev, lval_prev, in_primed;
    logic [PIX_W-1:0] data_q;
    logic             fval_rise, fval_fall, lval_fall;
    logic [CW-1:0]    col, win_cs, win_cc;
    logic [RW-1:0]    row, win_rs, win_rc;
    logic [CW:0]      col_end;
    logic [RW:0]      row_end;
    logic             in_win, eol_hit, first_done;
    logic             pix_evt, want_push, push, pop, overflow_evt, frame_end;
    logic [OUT_W-1:0] pix_out;
    tSPixelBeat       push_beat, head;
    logic             fifo_full, fifo_empty;
    logic             unused_bits;

    // in_primed marks that fval_q holds a real pad sample rather than its reset value.
    always_ff @(posedge ul1Clock or posedge ul1Reset) begin
        if (ul1Reset) begin
            fval_q    <= 1'b0;
            lval_q    <= 1'b0;
            data_q    <= '0;
            fval_prev <= 1'b0;
            lval_prev <= 1'b0;
            in_primed <= 1'b0;
        end else begin
            fval_q    <= ul1Fval;
            lval_q    <= ul1Lval;
            data_q    <= ulData;
            fval_prev <= fval_q;
            lval_prev <= lval_q;
            in_primed <= 1'b1;
        end
    end

    assign fval_rise = fval_q && !fval_prev;
    assign fval_fall = !fval_q && fval_prev;
    assign lval_fall = !lval_q && lval_prev;

    assign col_end = {1'b0, win_cs} + {1'b0, win_cc};
    assign row_end = {1'b0, win_rs} + {1'b0, win_rc};
    assign in_win  = (col >= win_cs) && ({1'b0, col} < col_end)
                  && (row >= win_rs) && ({1'b0, row} < row_end);
    assign eol_hit = (({1'b0, col}) + (CW+1)'(1)) == col_end;

`ifdef TRDB_D5M_TEST_PATTERN_EN
    assign pix_out = OUT_W'({4'(row), 8'(col)});
`else
    assign pix_out = data_q[PIX_W-1 -: OUT_W];
`endif

    assign pop = !fifo_empty && ul1Ready;

    always_comb begin
        state_d      = state_q;
        pix_evt      = (state_q == IN_FRAME) && lval_q && !fval_fall;
        want_push    = pix_evt && in_win;
        push         = want_push && (!fifo_full || pop);
        overflow_evt = want_push && fifo_full && !pop;
        frame_end    = ((state_q == IN_FRAME) || (state_q == DROP)) && fval_fall;
        case (state_q)
            SYNC:       if (in_primed && !fval_q) state_d = WAIT_FRAME;
            WAIT_FRAME: if (fval_rise) state_d = IN_FRAME;
            IN_FRAME: begin
                if (fval_fall)         state_d = WAIT_FRAME;
                else if (overflow_evt) state_d = DROP;
            end
            DROP:       if (fval_fall) state_d = WAIT_FRAME;
            default:    state_d = SYNC;
        endcase
    end

    always_ff @(posedge ul1Clock or posedge ul1Reset) begin
        if (ul1Reset) state_q <= SYNC;
        else          state_q <= state_d;
    end

    always_ff @(posedge ul1Clock or posedge ul1Reset) begin
        if (ul1Reset) begin
            col          <= '0;
            row          <= '0;
            win_cs       <= '0;
            win_cc       <= '0;
            win_rs       <= '0;
            win_rc       <= '0;
            first_done   <= 1'b0;
            ul1Overflow  <= 1'b0;
            ulFrameCount <= '0;
        end else begin
            if ((state_q == WAIT_FRAME) && fval_rise) begin
                win_cs     <= ulColStart;
                win_cc     <= ulColCount;
                win_rs     <= ulRowStart;
                win_rc     <= ulRowCount;
                col        <= '0;
                row        <= '0;
                first_done <= 1'b0;
            end else if ((state_q == IN_FRAME) || (state_q == DROP)) begin
                if (lval_q) begin
                    col <= (col == COL_MAX) ? col : col + CW'(1);
                end else if (lval_fall) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? row : row + RW'(1);
                end
                if (push) first_done <= 1'b1;
            end
            if (overflow_evt)     ul1Overflow <= 1'b1;
            else if (ul1ClearOvf) ul1Overflow <= 1'b0;
            if (frame_end) ulFrameCount <= ulFrameCount + FRAME_CNT_W'(1);
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.data = BEAT_DATA_W'(pix_out);
        push_beat.sof  = !first_done;
        push_beat.eol  = eol_hit;
    end

    trdb_d5m_pixel_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (ul1Clock),
        .rst       (ul1Reset),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ul1Valid    = !fifo_empty;
    assign ulPixel     = head.data[OUT_W-1:0];
    assign ul1Sof      = head.sof;
    assign ul1Eol      = head.eol;
    assign ul1Busy     = (state_q == IN_FRAME) || (state_q == DROP);
    assign unused_bits = ^{head.data, data_q};

endmodule

// File: doc/trdb_d5m_capture.md
Name: trdb_d5m_capture

Overview:
Parametrised successor to the TRDB_D5M driver stub. It captures the D5M sensor pixel bus (FVAL/LVAL/DATA, already synchronous to ul1Clock), applies a per-frame crop window and buffers pixels in a small FIFO. Its output is a valid/ready image-transfer stream tagged with start-of-frame and end-of-line. It sits between the D5M pads and the image-transfer sink, and reports frame count and sticky overflow to the control block.

Parameters:
PIX_W, 12, sensor pixel width.
OUT_W, 12, stream pixel width; must be <= PIX_W; the OUT_W MSBs of the pixel are kept.
FIFO_DEPTH, 16, pixel buffer entries; power of two, >= 2.
MAX_COLS, 2592, maximum sensor columns; column counter width CW = $clog2(MAX_COLS+1).
MAX_ROWS, 1944, maximum sensor rows; row counter width RW = $clog2(MAX_ROWS+1).

Ports:
ul1Clock  in  1  pixel clock; single clock domain.
ul1Reset  in  1  asynchronous, active-high reset.
ul1Fval  in  1  sensor frame valid.
ul1Lval  in  1  sensor line valid.
ulData  in  PIX_W  sensor pixel.
ulColStart  in  CW  crop first column.
ulColCount  in  CW  crop width; 0 means no output.
ulRowStart  in  RW  crop first row.
ulRowCount  in  RW  crop height; 0 means no output.
ul1ClearOvf  in  1  clears the sticky overflow flag.
ul1Valid  out  1  stream beat valid.
ul1Ready  in  1  sink ready.
ulPixel  out  OUT_W  stream pixel.
ul1Sof  out  1  first beat of the frame.
ul1Eol  out  1  last beat of a window line.
ul1Overflow  out  1  sticky; a pixel was dropped.
ulFrameCount  out  16  completed frames; wraps.
ul1Busy  out  1  state is IN_FRAME or DROP.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0. FIFO empty. State SYNC. Counters 0.
  - Input stage registers (fval_q, lval_q, data_q) cleared.
- Input stage: FVAL, LVAL and DATA are registered once. Edges are detected on the registered values.
- States: SYNC, WAIT_FRAME, IN_FRAME, DROP.
- SYNC: wait until fval_q = 0 → WAIT_FRAME. This discards any partial frame in progress at reset.
- WAIT_FRAME:
  - On fval_q rising: latch all four window inputs, set row = 0, col = 0, clear first-beat flag → IN_FRAME.
  - LVAL is ignored in this state.
- IN_FRAME:
  - Each cycle with lval_q = 1 is one pixel; col increments.
  - On lval_q falling: col = 0, row increments (saturating at MAX_ROWS).
  - A pixel is in-window if ColStart <= col < ColStart+ColCount and RowStart <= row < RowStart+RowCount. Sums are computed at CW+1/RW+1 bits, so there is no wrap.
  - In-window pixels are pushed as {data_q[PIX_W-1 -: OUT_W], sof, eol}.
  - sof = 1 on the first push of the frame.
  - eol = 1 when col == ColStart+ColCount-1.
  - A line that ends before the window end gets no eol.
- Overflow:
  - A push while the FIFO is full drops the pixel, sets ul1Overflow, and moves to DROP.
  - In DROP, all further pixels of the frame are discarded. Existing FIFO contents still drain.
- Frame end: on fval_q falling, from IN_FRAME or DROP → WAIT_FRAME and ulFrameCount increments. This happens even for an empty window or a dropped frame.
- Simultaneous overflow set and ul1ClearOvf: set wins.
- Window inputs that change mid-frame take effect at the next FVAL rise.
- FIFO is first-word-fall-through:
  - A pixel sampled at the pads in cycle N is written in cycle N+1 and appears on ul1Valid in cycle N+2 at the earliest.
  - Once ul1Valid = 1, it is held with ulPixel/ul1Sof/ul1Eol stable until ul1Ready = 1.
  - Push and pop in the same cycle while full is allowed only if the pop frees a slot first. The pop is evaluated before the full check.
- Reset mid-frame: the FIFO is flushed and no partial beats remain.

Optional Feature:
TRDB_D5M_TEST_PATTERN_EN:
- Defined: the pushed pixel is {row[3:0], col[7:0]} zero-extended or truncated to OUT_W, replacing sensor data. Timing, windowing and tags are unchanged.
- Undefined: sensor data passes through and there is no pattern logic.

Decomposition:
- Package trdb_d5m_pkg holds:
  - the state enum tECaptureState;
  - the struct tSPixelBeat {data, sof, eol}, parametrised via a localparam width;
  - the localparam FRAME_CNT_W = 16.
- Sub-module trdb_d5m_pixel_fifo: synchronous FWFT FIFO of tSPixelBeat with FIFO_DEPTH, full, empty, push and pop.

Test Plan:
1. 8x4 frame, window col 2/width 3, row 1/height 2, ready = 1, test pattern on → 6 beats: 0x102, 0x103, 0x104, 0x202, 0x203, 0x204; sof on beat 1; eol on beats 3 and 6; ulFrameCount = 1.
2. ready = 0, one 20-pixel line, full window, FIFO_DEPTH = 16 → 16 beats stored and ul1Overflow = 1. Raise ready → exactly 16 beats drain. The next frame captures normally. A ClearOvf pulse drops the flag.
3. Reset asserted mid-line with FVAL = 1 → all outputs 0 within the same cycle. After release with FVAL still high, there are no beats until FVAL falls and rises again.
4. ColCount = 0 for one 4x4 frame → no ul1Valid; ulFrameCount still increments.
5. ColStart changed from 2 to 0 mid-frame → the current frame uses 2; the next frame's first beat is column 0.
6. Latency: an isolated single pixel at pads in cycle N with ready = 1 → ul1Valid is high in cycle N+2 only.
